avg_sample_streamer: RTL and testbench

//   Source side of the 8-bit sample stream consumed by the pairwise averager.

---
 rtl/avg_sample_streamer_if.sv | 36 +++
 rtl/avg_sample_streamer.sv | 141 ++++++++++++++
 tb/tb_avg_sample_streamer.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/avg_sample_streamer_if.sv
//------------------------------------------------------------------------------
// avg_sample_streamer_if
//   Buffer write port and valid/ready sample stream of avg_sample_streamer.
//   master: the streamer side.  slave: the host/sink side.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface avg_sample_streamer_if #(
   parameter int DW = 8,
   parameter int AW = 7
);
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          start;
   logic [AW:0]   len;
   logic [DW-1:0] data;
   logic          data_valid;
   logic          data_ready;
   logic          busy;
   logic          done;
   logic          wr_err;

   modport master (
      input  wr_en, wr_addr, wr_data, start, len, data_ready,
      output data, data_valid, busy, done, wr_err
   );

   modport slave (
      output wr_en, wr_addr, wr_data, start, len, data_ready,
      input  data, data_valid, busy, done, wr_err
   );
endinterface

`default_nettype wire

// File: rtl/avg_sample_streamer.sv
//------------------------------------------------------------------------------
// avg_sample_streamer
//   Host-loaded sample buffer replayed as a one-beat-per-transfer
//   valid/ready stream of the first len entries, followed by a done pulse.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module avg_sample_streamer #(
   parameter int DW    = 8,
   parameter int DEPTH = 128,
   parameter int AW    = 7
) (
   input  wire logic              clk,
   input  wire logic              reset,   // asynchronous, active low
   avg_sample_streamer_if.master  bus
);

   localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_STREAM = 1'b1
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;

   logic [DW-1:0] r_mem [DEPTH];
   logic [DW-1:0] r_data;
   logic          r_valid;
   logic          r_done;
   logic          r_wr_err;
   logic [AW-1:0] r_idx;
   logic [AW:0]   r_len_q;

   logic          w_xfer;
   logic          w_last;
   logic [AW:0]   w_len_cap;
   logic [AW:0]   w_len_m1;
   logic [AW-1:0] w_idx_inc;
   logic [AW-1:0] w_rd_addr;

   assign w_xfer    = r_valid & bus.data_ready;
   assign w_len_m1  = r_len_q - 1'b1;
   assign w_last    = ({1'b0, r_idx} == w_len_m1);
   assign w_len_cap = (bus.len > c_DEPTH) ? c_DEPTH : bus.len;
   assign w_idx_inc = r_idx + 1'b1;
   // In IDLE the only read is the first beat; in STREAM it is the next beat.
   assign w_rd_addr = (r_state == S_IDLE) ? '0 : w_idx_inc;

   assign bus.data       = r_data;
   assign bus.data_valid = r_valid;
   assign bus.busy       = (r_state == S_STREAM);
   assign bus.done       = r_done;
   assign bus.wr_err     = r_wr_err;

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic: a zero-length start stays in IDLE.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.start && (w_len_cap != '0)) begin
               w_state_nxt = S_STREAM;
            end
         end
         S_STREAM: begin
            if (w_xfer && w_last) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Stream datapath: beat register, index, captured length and pulses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_data   <= '0;
         r_valid  <= 1'b0;
         r_done   <= 1'b0;
         r_wr_err <= 1'b0;
         r_idx    <= '0;
         r_len_q  <= '0;
      end else begin
         r_done   <= 1'b0;
         r_wr_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_len_q <= w_len_cap;
                  r_idx   <= '0;
                  if (w_len_cap != '0) begin
                     // Reads the pre-write contents if a write to entry 0
                     // lands on this same edge.
                     r_data  <= r_mem[w_rd_addr];
                     r_valid <= 1'b1;
                  end else begin
                     r_done  <= 1'b1;
                  end
               end
            end
            S_STREAM: begin
               if (bus.wr_en) begin
                  r_wr_err <= 1'b1;
               end
               if (w_xfer) begin
                  if (w_last) begin
                     r_valid <= 1'b0;
                     r_data  <= '0;
                     r_done  <= 1'b1;
                  end else begin
                     r_data  <= r_mem[w_rd_addr];
                     r_idx   <= w_idx_inc;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Sample buffer: host writes accepted only while IDLE, never cleared.
   always_ff @(posedge clk) begin
      if ((r_state == S_IDLE) && bus.wr_en) begin
         r_mem[bus.wr_addr] <= bus.wr_data;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_avg_sample_streamer.sv
//------------------------------------------------------------------------------
// tb_avg_sample_streamer
//   Directed self-checking bench for avg_sample_streamer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_avg_sample_streamer;

   logic clk;
   logic reset;

   avg_sample_streamer_if #(.DW(8), .AW(7)) bus ();

   avg_sample_streamer #(.DW(8), .DEPTH(128), .AW(7)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks   = 0;
   int failures = 0;

   logic [7:0] cap_q [$];
   int n_done, n_wrerr, n_busy, n_valid, n_unstable, n_gap;
   int c_last_beat, c_done;
   int inj_cycle  = -1;
   int stop_beats = -1;

   // Host write of one buffer entry (stimulus only).
   task automatic write_buf(input logic [6:0] a, input logic [7:0] d);
      @(negedge clk);
      bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
      @(negedge clk);
      bus.wr_en = 1'b0;
   endtask

   // Raise start on the next falling edge; collect() drops it again.
   task automatic start_stream(input logic [7:0] l);
      @(negedge clk);
      bus.start = 1'b1; bus.len = l;
   endtask

   // Sink model: records accepted beats and event counts, no checking.
   task automatic collect(input int max_cyc, input bit stall_mode);
      logic pv, pr;
      logic [7:0] pd;
      cap_q.delete();
      n_done = 0; n_wrerr = 0; n_busy = 0; n_valid = 0; n_unstable = 0; n_gap = 0;
      c_last_beat = -1; c_done = -1;
      pv = 1'b0; pr = 1'b0; pd = '0;
      for (int c = 0; c < max_cyc; c++) begin
         @(negedge clk);
         if (c == 0) bus.start = 1'b0;
         if (c == inj_cycle) begin
            bus.start = 1'b1; bus.len = 8'd5;
            bus.wr_en = 1'b1; bus.wr_addr = 7'd3; bus.wr_data = 8'hFF;
         end
         if (c == inj_cycle + 1) begin
            bus.start = 1'b0; bus.wr_en = 1'b0;
         end
         if (stop_beats >= 0 && cap_q.size() == stop_beats) return;
         if (bus.busy) n_busy++;
         if (bus.done) begin
            n_done++;
            if (c_done < 0) c_done = c;
         end
         if (bus.wr_err) n_wrerr++;
         if (bus.data_valid) n_valid++;
         if (pv && !pr && (!bus.data_valid || bus.data !== pd)) n_unstable++;
         if (!stall_mode && cap_q.size() > 0 && n_done == 0 && !bus.data_valid) n_gap++;
         bus.data_ready = stall_mode ? (c % 3 == 0) : 1'b1;
         if (bus.data_valid && bus.data_ready) begin
            cap_q.push_back(bus.data);
            c_last_beat = c;
         end
         pv = bus.data_valid; pr = bus.data_ready; pd = bus.data;
         if (c_done >= 0 && c >= c_done + 2) break;
      end
   endtask

   task automatic test_reset;
      reset = 1'b0;
      bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
      bus.start = 1'b0; bus.len = '0; bus.data_ready = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.data, bus.data_valid, bus.busy, bus.done, bus.wr_err} !== 12'h000) begin
         failures++;
         $display("FAIL reset_outputs: got data=%h v=%b busy=%b done=%b err=%b, want all 0",
                  bus.data, bus.data_valid, bus.busy, bus.done, bus.wr_err);
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.data_valid !== 1'b0 || bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL idle_after_reset: got v=%b busy=%b, want 0 0", bus.data_valid, bus.busy);
      end
   endtask

   task automatic test_full_stream;
      for (int i = 0; i < 128; i++) write_buf(7'(i), 8'(2 * i));
      start_stream(8'd128);
      collect(300, 1'b0);
      checks++;
      if (cap_q.size() != 128) begin
         failures++;
         $display("FAIL full_beats: got %0d beats, want 128", cap_q.size());
      end
      for (int i = 0; i < cap_q.size(); i++) begin
         checks++;
         if (cap_q[i] !== 8'(2 * i)) begin
            failures++;
            $display("FAIL full_data[%0d]: got %h, want %h", i, cap_q[i], 8'(2 * i));
            break;
         end
      end
      checks++;
      if (n_busy != 128) begin
         failures++;
         $display("FAIL full_busy_cycles: got %0d, want 128", n_busy);
      end
      checks++;
      if (n_done != 1 || c_done != c_last_beat + 1) begin
         failures++;
         $display("FAIL full_done: got %0d pulses at cycle %0d (last beat %0d), want 1 at last+1",
                  n_done, c_done, c_last_beat);
      end
   endtask

   task automatic test_stall;
      start_stream(8'd16);
      collect(200, 1'b1);
      checks++;
      if (cap_q.size() != 16) begin
         failures++;
         $display("FAIL stall_beats: got %0d, want 16", cap_q.size());
      end
      for (int i = 0; i < cap_q.size(); i++) begin
         checks++;
         if (cap_q[i] !== 8'(2 * i)) begin
            failures++;
            $display("FAIL stall_data[%0d]: got %h, want %h", i, cap_q[i], 8'(2 * i));
            break;
         end
      end
      checks++;
      if (n_unstable != 0) begin
         failures++;
         $display("FAIL stall_hold: got %0d unstable cycles, want 0", n_unstable);
      end
      checks++;
      if (n_done != 1) begin
         failures++;
         $display("FAIL stall_done: got %0d pulses, want 1", n_done);
      end
   endtask

   task automatic test_len_zero;
      start_stream(8'd0);
      collect(10, 1'b0);
      checks++;
      if (c_done != 0 || n_done != 1) begin
         failures++;
         $display("FAIL len0_done: got %0d pulses first at cycle %0d, want 1 at cycle 0", n_done, c_done);
      end
      checks++;
      if (n_valid != 0 || n_busy != 0) begin
         failures++;
         $display("FAIL len0_quiet: got valid=%0d busy=%0d cycles, want 0 0", n_valid, n_busy);
      end
   endtask

   task automatic test_busy_start_write;
      start_stream(8'd128);
      inj_cycle = 1;
      collect(300, 1'b0);
      inj_cycle = -1;
      checks++;
      if (cap_q.size() != 128) begin
         failures++;
         $display("FAIL busy_start_len: got %0d beats, want 128", cap_q.size());
      end
      checks++;
      if (cap_q.size() > 3 && cap_q[3] !== 8'h06) begin
         failures++;
         $display("FAIL busy_write_beat3: got %h, want 06", cap_q[3]);
      end
      checks++;
      if (n_wrerr != 1) begin
         failures++;
         $display("FAIL busy_wr_err: got %0d pulses, want 1", n_wrerr);
      end
      start_stream(8'd5);
      collect(50, 1'b0);
      checks++;
      if (cap_q.size() != 5 || cap_q[3] !== 8'h06) begin
         failures++;
         $display("FAIL rerun_beat3: got %0d beats, beat3=%h, want 5 beats, 06",
                  cap_q.size(), (cap_q.size() > 3) ? cap_q[3] : 8'hxx);
      end
   endtask

   task automatic test_reset_mid;
      start_stream(8'd128);
      stop_beats = 40;
      collect(300, 1'b0);
      stop_beats = -1;
      checks++;
      if (bus.data_valid !== 1'b1 || bus.data !== 8'd80) begin
         failures++;
         $display("FAIL mid_beat40: got v=%b data=%h, want 1 50", bus.data_valid, bus.data);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({bus.data, bus.data_valid, bus.busy, bus.done, bus.wr_err} !== 12'h000) begin
         failures++;
         $display("FAIL mid_async_reset: got data=%h v=%b busy=%b done=%b err=%b, want all 0",
                  bus.data, bus.data_valid, bus.busy, bus.done, bus.wr_err);
      end
      n_done = 0;
      repeat (2) begin
         @(negedge clk);
         if (bus.done) n_done++;
      end
      reset = 1'b1;
      repeat (2) begin
         @(negedge clk);
         if (bus.done) n_done++;
      end
      checks++;
      if (n_done != 0) begin
         failures++;
         $display("FAIL mid_no_done: got %0d pulses, want 0", n_done);
      end
      start_stream(8'd4);
      collect(50, 1'b0);
      checks++;
      if (cap_q.size() != 4 || cap_q[0] !== 8'd0 || cap_q[1] !== 8'd2 ||
          cap_q[2] !== 8'd4 || cap_q[3] !== 8'd6) begin
         failures++;
         $display("FAIL post_reset_beats: got %0d beats, want 00 02 04 06", cap_q.size());
      end
   endtask

   task automatic test_averager_feed;
      for (int i = 0; i < 128; i++) write_buf(7'(i), 8'(i));
      start_stream(8'd128);
      collect(300, 1'b0);
      checks++;
      if (cap_q.size() != 128 || n_gap != 0) begin
         failures++;
         $display("FAIL feed_count_gaps: got %0d beats %0d gaps, want 128 0", cap_q.size(), n_gap);
      end
      for (int i = 0; i < cap_q.size(); i++) begin
         checks++;
         if (cap_q[i] !== 8'(i)) begin
            failures++;
            $display("FAIL feed_data[%0d]: got %h, want %h", i, cap_q[i], 8'(i));
            break;
         end
      end
      start_stream(8'd255);
      collect(300, 1'b0);
      checks++;
      if (cap_q.size() != 128 || cap_q[cap_q.size()-1] !== 8'd127) begin
         failures++;
         $display("FAIL len_clamp: got %0d beats, want 128 ending at 7f", cap_q.size());
      end
   endtask

   task automatic test_back_to_back;
      bus.data_ready = 1'b1;
      // start accepted in the done cycle
      start_stream(8'd2);
      @(negedge clk); bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL b2b_done: got done=%b busy=%b, want 1 0", bus.done, bus.busy);
      end
      bus.start = 1'b1; bus.len = 8'd1;
      @(negedge clk); bus.start = 1'b0;
      checks++;
      if (bus.data_valid !== 1'b1 || bus.busy !== 1'b1) begin
         failures++;
         $display("FAIL b2b_restart: got v=%b busy=%b, want 1 1", bus.data_valid, bus.busy);
      end
      @(negedge clk);
      // write then start on the next cycle sees the new value
      bus.wr_en = 1'b1; bus.wr_addr = 7'd0; bus.wr_data = 8'h5A;
      @(negedge clk);
      bus.wr_en = 1'b0; bus.start = 1'b1; bus.len = 8'd1;
      @(negedge clk); bus.start = 1'b0;
      checks++;
      if (bus.data_valid !== 1'b1 || bus.data !== 8'h5A) begin
         failures++;
         $display("FAIL write_then_start: got v=%b data=%h, want 1 5a", bus.data_valid, bus.data);
      end
      @(negedge clk);
      // simultaneous write and start: beat is the pre-write value
      bus.wr_en = 1'b1; bus.wr_addr = 7'd0; bus.wr_data = 8'h33;
      bus.start = 1'b1; bus.len = 8'd1;
      @(negedge clk);
      bus.wr_en = 1'b0; bus.start = 1'b0;
      checks++;
      if (bus.data !== 8'h5A) begin
         failures++;
         $display("FAIL same_cycle_read: got %h, want 5a", bus.data);
      end
      @(negedge clk);
      bus.start = 1'b1; bus.len = 8'd1;
      @(negedge clk); bus.start = 1'b0;
      checks++;
      if (bus.data !== 8'h33) begin
         failures++;
         $display("FAIL same_cycle_write: got %h, want 33", bus.data);
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_full_stream();
      test_stall();
      test_len_zero();
      test_busy_start_write();
      test_reset_mid();
      test_averager_feed();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
